// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the data-SRAM request path: access-size
// codes and the alignment, byte-strobe and store-data replication rules.
package mem_ctrl_pkg;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  // Tracker entry layout: {wr, cancel}
  localparam int TRK_W = 2;

  // Misaligned when the low address bits are not a multiple of the access size.
  function automatic logic size_ale(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      SIZE_H:  size_ale = addr_lo[0];
      SIZE_W:  size_ale = |addr_lo[1:0];
      SIZE_D:  size_ale = |addr_lo;
      default: size_ale = 1'b0;
    endcase
  endfunction

  // Byte strobes on an 8-lane bus; 32-bit callers pass addr_lo[2]=0 and keep
  // the low four lanes.
  function automatic logic [7:0] size_wstrb(input logic [1:0] size, input logic [2:0] addr_lo);
    case (size)
      SIZE_B:  size_wstrb = 8'h01 << addr_lo;
      SIZE_H:  size_wstrb = 8'h03 << {addr_lo[2:1], 1'b0};
      SIZE_W:  size_wstrb = 8'h0F << {addr_lo[2], 2'b00};
      default: size_wstrb = 8'hFF;
    endcase
  endfunction

  // Replicate the right-justified store datum across every lane so the bus
  // can pick it up at whatever byte offset the strobes select.
  function automatic logic [63:0] size_wdata(input logic [1:0] size, input logic [63:0] data);
    case (size)
      SIZE_B:  size_wdata = {8{data[7:0]}};
      SIZE_H:  size_wdata = {4{data[15:0]}};
      SIZE_W:  size_wdata = {2{data[31:0]}};
      default: size_wdata = data;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count, a clear input that empties it, and a
// broadcast input that sets bit 0 of every stored entry (used as the cancel
// flag by the request tracker). Bit 0 is kept in its own reset flag vector;
// the remaining payload bits are plain storage.
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             clear,
  input  logic             cancel_all,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-2:0] mem [DEPTH];
  logic [DEPTH-1:0] flag_q;
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    ptr_next = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);
  assign rdata   = {mem[rptr], flag_q[rptr]};

  // Pointers, occupancy and per-entry flag bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      flag_q <= '0;
    end else begin
      if (clear) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (do_push) wptr <= ptr_next(wptr);
        if (do_pop)  rptr <= ptr_next(rptr);
        if (do_push && !do_pop)      count <= count + 1'b1;
        else if (do_pop && !do_push) count <= count - 1'b1;
      end
      if (cancel_all) flag_q <= '1;
      if (do_push)    flag_q[wptr] <= wdata[0];
    end
  end

  // Payload storage; contents are only meaningful behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata[WIDTH-1:1];
  end

endmodule

// File: rtl/data_sram_req_ctrl.sv
// Data-SRAM request controller between execute and memory stages. Issues up
// to MAX_OUTST pipelined requests, consumes misaligned requests without bus
// traffic, and on flush tags in-flight requests so their responses are
// discarded while new requests keep issuing against the remaining credit.
module data_sram_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [1:0]          req_size,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                req_ale,
  input  logic                flush,
  output logic                sram_req,
  output logic                sram_wr,
  output logic [1:0]          sram_size,
  output logic [DATA_W/8-1:0] sram_wstrb,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic                sram_addr_ok,
  input  logic                sram_data_ok,
  input  logic [DATA_W-1:0]   sram_rdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_wr,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                err_unexp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CW     = $clog2(MAX_OUTST + 1);
  localparam int RSP_W  = 1 + DATA_W;

  logic [2:0]       lane_lo;
  logic [CW:0]      credit;
  logic             full;

  logic             trk_push;
  logic             trk_pop;
  logic [TRK_W-1:0] trk_head;
  logic             trk_full;
  logic             trk_empty;
  logic [CW-1:0]    trk_count;
  logic             head_cancel;

  logic             rsp_push;
  logic             rsp_pop;
  logic [RSP_W-1:0] rsp_head;
  logic             rsp_full;
  logic             rsp_empty;
  logic [CW-1:0]    rsp_count;

  // A 32-bit bus has four lanes, so address bit 2 never selects a lane.
  assign lane_lo = (DATA_W == 64) ? req_addr[2:0] : {1'b0, req_addr[1:0]};

  // Doubleword on a 32-bit bus cannot be carried, so it is reported as misaligned.
  assign req_ale = size_ale(req_size, req_addr[2:0]) | ((req_size == SIZE_D) && (DATA_W != 64));

  // Credit covers both requests awaiting data and responses awaiting pickup,
  // which guarantees a returning response always finds room in the buffer.
  assign credit = {1'b0, trk_count} + {1'b0, rsp_count};
  assign full   = (credit == (CW + 1)'(MAX_OUTST));

  assign sram_req   = req_valid & ~req_ale & ~full & ~flush;
  assign req_ready  = (sram_req & sram_addr_ok) | (req_valid & req_ale & ~flush);
  assign sram_wr    = req_wr;
  assign sram_size  = req_size;
  assign sram_addr  = req_addr;
  assign sram_wstrb = req_wr ? STRB_W'(size_wstrb(req_size, lane_lo)) : '0;
  assign sram_wdata = DATA_W'(size_wdata(req_size, 64'(req_wdata)));

  // A response popped in the flush cycle belongs to the cancelled batch too.
  assign trk_push    = sram_req & sram_addr_ok & ~trk_full;
  assign trk_pop     = sram_data_ok & ~trk_empty;
  assign head_cancel = trk_head[0] | flush;

  assign rsp_push  = trk_pop & ~head_cancel & (~rsp_full | rsp_pop);
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_valid = ~rsp_empty;
  assign rsp_wr    = rsp_head[RSP_W-1];
  assign rsp_rdata = rsp_head[DATA_W-1:0];

  sync_fifo #(
    .WIDTH (TRK_W),
    .DEPTH (MAX_OUTST)
  ) u_trk (
    .clk        (clk),
    .resetn     (resetn),
    .push       (trk_push),
    .wdata      ({req_wr, 1'b0}),
    .pop        (trk_pop),
    .clear      (1'b0),
    .cancel_all (flush),
    .rdata      (trk_head),
    .full       (trk_full),
    .empty      (trk_empty),
    .count      (trk_count)
  );

  sync_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (MAX_OUTST)
  ) u_rsp (
    .clk        (clk),
    .resetn     (resetn),
    .push       (rsp_push),
    .wdata      ({trk_head[1], sram_rdata}),
    .pop        (rsp_pop),
    .clear      (flush),
    .cancel_all (1'b0),
    .rdata      (rsp_head),
    .full       (rsp_full),
    .empty      (rsp_empty),
    .count      (rsp_count)
  );

  // Sticky flag for a response that arrives with nothing tracked.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                       err_unexp <= 1'b0;
    else if (sram_data_ok && trk_empty) err_unexp <= 1'b1;
  end

endmodule

// File: tb/tb_data_sram_req_ctrl.sv
// Bench for data_sram_req_ctrl: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the request rules.
module tb_data_sram_req_ctrl;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn;
  logic          req_valid, req_ready, req_wr, req_ale, flush;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          sram_req, sram_wr, sram_addr_ok, sram_data_ok;
  logic [1:0]    sram_size;
  logic [3:0]    sram_wstrb;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic          rsp_valid, rsp_ready, rsp_wr, err_unexp;
  logic [DW-1:0] rsp_rdata;

  logic          r64_valid, r64_wr, w64_ready, w64_ale, w64_req, w64_wr;
  logic [1:0]    r64_size, w64_size;
  logic [AW-1:0] r64_addr, w64_addr;
  logic [63:0]   r64_wdata, w64_wdata, w64_rdata;
  logic [7:0]    w64_wstrb;
  logic          w64_rsp_valid, w64_rsp_wr, w64_err;

  data_sram_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MAXO)) u_dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .req_ale(req_ale), .flush(flush),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size), .sram_wstrb(sram_wstrb),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
    .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata), .err_unexp(err_unexp)
  );

  data_sram_req_ctrl #(.ADDR_W(AW), .DATA_W(64), .MAX_OUTST(MAXO)) u_dut64 (
    .clk(clk), .resetn(resetn), .req_valid(r64_valid), .req_ready(w64_ready), .req_wr(r64_wr),
    .req_size(r64_size), .req_addr(r64_addr), .req_wdata(r64_wdata), .req_ale(w64_ale), .flush(1'b0),
    .sram_req(w64_req), .sram_wr(w64_wr), .sram_size(w64_size), .sram_wstrb(w64_wstrb),
    .sram_addr(w64_addr), .sram_wdata(w64_wdata), .sram_addr_ok(1'b0),
    .sram_data_ok(1'b0), .sram_rdata(64'h0), .rsp_valid(w64_rsp_valid), .rsp_ready(1'b0),
    .rsp_wr(w64_rsp_wr), .rsp_rdata(w64_rdata), .err_unexp(w64_err)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct { bit wr; bit cancel; } trk_t;
  typedef struct { bit wr; logic [31:0] data; } rsp_t;
  trk_t trk_q[$];
  rsp_t rsp_q[$];
  bit   m_err;

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic bit m_ale(input logic [1:0] s, input logic [31:0] a, input int dw);
    if (s == 2'd3 && dw != 64) return 1'b1;
    return (a % nbytes(s)) != 0;
  endfunction

  function automatic logic [7:0] m_strb(input logic [1:0] s, input logic [31:0] a, input int dw);
    int nb, off;
    logic [15:0] m;
    nb  = nbytes(s);
    off = ((a % (dw / 8)) / nb) * nb;
    m   = ((16'd1 << nb) - 16'd1) << off;
    return m[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [1:0] s, input logic [63:0] d, input int dw);
    int nb;
    logic [63:0] piece, r;
    nb    = nbytes(s);
    piece = (nb == 8) ? d : (d & ((64'd1 << (8 * nb)) - 64'd1));
    r     = '0;
    for (int k = 0; k < dw / (8 * nb); k++) r |= piece << (8 * nb * k);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit v, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input bit aok, input bit dok, input logic [31:0] rd,
                        input bit rr, input bit fl);
    req_valid = v; req_wr = wr; req_size = sz; req_addr = a; req_wdata = wd;
    sram_addr_ok = aok; sram_data_ok = dok; sram_rdata = rd; rsp_ready = rr; flush = fl;
  endtask

  // Compare outputs against the model, then advance the model across one edge.
  task automatic step();
    bit e_full, e_ale, e_req, e_ready, take;
    logic [7:0]  s8;
    logic [63:0] w64;
    trk_t h;
    rsp_t r;
    take = 1'b0;
    #2;
    e_full  = (trk_q.size() + rsp_q.size()) == MAXO;
    e_ale   = m_ale(req_size, req_addr, DW);
    e_req   = req_valid && !e_ale && !e_full && !flush;
    e_ready = (e_req && sram_addr_ok) || (req_valid && e_ale && !flush);
    chk("sram_req", sram_req, e_req);
    chk("req_ready", req_ready, e_ready);
    chk("req_ale", req_ale, e_ale);
    if (e_req) begin
      chk("sram_wr", sram_wr, req_wr);
      chk("sram_addr", sram_addr, req_addr);
      chk("sram_size", sram_size, req_size);
      s8 = req_wr ? m_strb(req_size, req_addr, DW) : 8'h0;
      chk("sram_wstrb", sram_wstrb, s8[3:0]);
      if (req_wr) begin
        w64 = m_wdata(req_size, {32'h0, req_wdata}, DW);
        chk("sram_wdata", sram_wdata, w64[31:0]);
      end
    end
    chk("rsp_valid", rsp_valid, rsp_q.size() > 0);
    if (rsp_q.size() > 0) begin
      chk("rsp_wr", rsp_wr, rsp_q[0].wr);
      chk("rsp_rdata", rsp_rdata, rsp_q[0].data);
    end
    chk("err_unexp", err_unexp, m_err);

    if (sram_data_ok) begin
      if (trk_q.size() == 0) m_err = 1'b1;
      else begin
        h    = trk_q.pop_front();
        take = !h.cancel && !flush;
      end
    end
    if (flush) rsp_q.delete();
    else begin
      if (rsp_q.size() > 0 && rsp_ready) r = rsp_q.pop_front();
      if (take) rsp_q.push_back('{h.wr, sram_rdata});
    end
    if (flush) foreach (trk_q[i]) trk_q[i].cancel = 1'b1;
    if (e_req && sram_addr_ok) trk_q.push_back('{req_wr, 1'b0});
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit aok, input bit dok, input logic [31:0] rd,
                       input bit rr, input bit fl);
    set_in(v, wr, sz, a, wd, aok, dok, rd, rr, fl);
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  s;
    logic [31:0] a;

    resetn = 1'b0;
    m_err  = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    r64_valid = 0; r64_wr = 0; r64_size = 0; r64_addr = 0; r64_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_err", err_unexp, 1'b0);
    chk("rst_sram_req", sram_req, 1'b0);
    @(posedge clk);
    #1;

    // Back-to-back loads, third stalls on credit, responses in order.
    drive(1, 0, 2, 32'h100, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 2, 32'h104, 0, 1, 0, 0, 0, 0);
    set_in(1, 0, 2, 32'h108, 0, 1, 0, 0, 0, 0);
    #1; chk("t1_stall", sram_req, 1'b0);
    step();
    drive(1, 0, 2, 32'h108, 0, 1, 1, 32'h11111111, 1, 0);
    set_in(1, 0, 2, 32'h108, 0, 1, 1, 32'h22222222, 1, 0);
    #1; chk("t1_rsp0", rsp_rdata, 32'h11111111);
    step();
    set_in(1, 0, 2, 32'h108, 0, 1, 0, 0, 1, 0);
    #1; chk("t1_rsp1", rsp_rdata, 32'h22222222); chk("t1_third_issue", sram_req, 1'b1);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 32'h33333333, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Misaligned half/word stores are consumed without bus traffic.
    set_in(1, 1, 1, 32'h203, 32'h1234, 1, 0, 0, 1, 0);
    #1; chk("t2_sh_ale", req_ale, 1'b1); chk("t2_sh_ready", req_ready, 1'b1); chk("t2_sh_req", sram_req, 1'b0);
    step();
    set_in(1, 1, 2, 32'h102, 32'h5678, 1, 0, 0, 1, 0);
    #1; chk("t2_sw_ale", req_ale, 1'b1); chk("t2_sw_ready", req_ready, 1'b1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Byte store strobes and replication.
    set_in(1, 1, 0, 32'h3, 32'hA5, 1, 0, 0, 1, 0);
    #1; chk("t3_sb_strb", sram_wstrb, 4'b1000); chk("t3_sb_wdata", sram_wdata, 32'hA5A5A5A5);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hFFFF0000, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    r64_valid = 1; r64_wr = 1; r64_size = 3; r64_addr = 32'h8; r64_wdata = 64'h0123456789ABCDEF;
    #1; chk("t3_sd_req", w64_req, 1'b1); chk("t3_sd_strb", w64_wstrb, 8'hFF); chk("t3_sd_wdata", w64_wdata, 64'h0123456789ABCDEF);
    r64_size = 0; r64_addr = 32'h5; r64_wdata = 64'hA5;
    #1; chk("t3_sb64_strb", w64_wstrb, 8'h20); chk("t3_sb64_wdata", w64_wdata, 64'hA5A5A5A5A5A5A5A5);
    r64_size = 2; r64_addr = 32'h4; r64_wdata = 64'hDEADBEEF;
    #1; chk("t3_sw64_strb", w64_wstrb, 8'hF0); chk("t3_sw64_wdata", w64_wdata, 64'hDEADBEEFDEADBEEF);
    r64_size = 3; r64_addr = 32'h4;
    #1; chk("t3_sd64_ale", w64_ale, 1'b1); chk("t3_sd64_noreq", w64_req, 1'b0);
    r64_valid = 0;
    @(posedge clk);
    #1;

    // Flush with two loads in flight; their responses are dropped.
    drive(1, 0, 2, 32'h200, 0, 1, 0, 0, 1, 0);
    drive(1, 0, 2, 32'h204, 0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 0, 2, 32'h300, 0, 1, 1, 32'hDEAD0001, 1, 0);
    set_in(1, 0, 2, 32'h300, 0, 1, 1, 32'hDEAD0002, 1, 0);
    #1; chk("t4_new_issue", sram_req, 1'b1); chk("t4_no_rsp", rsp_valid, 1'b0);
    step();
    drive(0, 0, 0, 0, 0, 0, 1, 32'hC0DE0003, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1; chk("t4_only_rsp", rsp_rdata, 32'hC0DE0003);
    step();

    // data_ok coinciding with flush, then an unexpected data_ok.
    drive(1, 0, 2, 32'h400, 0, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0, 1, 1);
    set_in(0, 0, 0, 0, 0, 0, 1, 32'h12345678, 1, 0);
    #1; chk("t5_dropped", rsp_valid, 1'b0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    #1; chk("t5_err", err_unexp, 1'b1);
    step();

    // Reset in the middle of two tracked requests.
    drive(1, 0, 2, 32'h500, 0, 1, 0, 0, 0, 0);
    drive(1, 0, 2, 32'h504, 0, 1, 0, 0, 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    trk_q.delete(); rsp_q.delete(); m_err = 1'b0;
    #2;
    chk("t6_rsp_valid", rsp_valid, 1'b0); chk("t6_err", err_unexp, 1'b0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    set_in(1, 0, 2, 32'h600, 0, 1, 0, 0, 0, 0);
    #1; chk("t6_issue", sram_req, 1'b1);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      s = 2'($urandom_range(0, 2));
      a = $urandom_range(0, 32'hFFF);
      if ($urandom % 4 != 0) a = a & ~(32'(nbytes(s)) - 32'd1);
      drive($urandom % 4 != 0, 1'($urandom), s, a, $urandom, $urandom % 4 != 0,
            (trk_q.size() > 0) && ($urandom % 2 == 1), $urandom, $urandom % 3 != 0,
            $urandom % 16 == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
